// File: rtl/cpu_clock_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller.
// FSM state encodings used by the top and any block that decodes controller state.
package cpu_clock_ctrl_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

endpackage

// File: rtl/cpu_clock_ctrl_btn_debounce.sv
// Board button conditioner: 2-flop synchroniser, stability counter and rising-edge pulse.
// Reusable for any raw push-button; level flips after DEBOUNCE_CYCLES stable differing cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic pulse
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = ~level_q;
      cnt_d   = '0;
      pulse_d = ~level_q;  // only the press direction produces a request
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Turns the slow divider square wave into one-cycle CPU clock enables.
// Supports free-run, single-step and sticky halt; everything runs on clk.
module cpu_clock_ctrl
  import cpu_clock_ctrl_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  logic             div1_q, div2_q, div3_q;
  logic             run1_q, run2_q;
  logic             tick, run_s, step_req, step_level;
  logic [1:0]       state_q, state_d;
  logic             cpu_en_q, cpu_en_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] count_q, count_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_W           (DB_W)
  ) u_step_db (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(step_btn),
    .level  (step_level),
    .pulse  (step_req)
  );

  // s3 low is required, so two ticks can never land on adjacent cycles
  assign tick  = div2_q & ~div3_q;
  assign run_s = run2_q;

  always_comb begin
    state_d  = state_q;
    cpu_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (halt)          state_d = ST_HALT;
        else if (run_s)    state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (halt)        state_d = ST_HALT;
        else if (!run_s) state_d = ST_IDLE;
        else if (tick)   cpu_en_d = 1'b1;
      end
      ST_STEP: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (tick) begin
          cpu_en_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_HALT;
    endcase
    count_d   = cpu_en_d ? count_q + CNT_W'(1) : count_q;
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div1_q    <= 1'b0;
      div2_q    <= 1'b0;
      div3_q    <= 1'b0;
      run1_q    <= 1'b0;
      run2_q    <= 1'b0;
      state_q   <= ST_IDLE;
      cpu_en_q  <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      div1_q    <= div_in;
      div2_q    <= div1_q;
      div3_q    <= div2_q;
      run1_q    <= run_sw;
      run2_q    <= run1_q;
      state_q   <= state_d;
      cpu_en_q  <= cpu_en_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      count_q   <= count_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Bench for cpu_clock_ctrl: directed scenarios, a cycle-level behavioural model
// checked every cycle, and literal checkpoints at hand-computed times.
module tb_cpu_clock_ctrl;

  localparam int DEB   = 4;
  localparam int CNT_W = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             div_in = 1'b1;
  logic             run_sw = 1'b0;
  logic             step_btn = 1'b0;
  logic             halt = 1'b0;
  logic             cpu_en, running, halted;
  logic [CNT_W-1:0] instr_count;

  int total = 0;
  int bad = 0;
  int pulses = 0;

  cpu_clock_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .DB_W           (16),
    .CNT_W          (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .run_sw     (run_sw),
    .step_btn   (step_btn),
    .halt       (halt),
    .cpu_en     (cpu_en),
    .running    (running),
    .halted     (halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // divider output: 200 ns period, edges offset from clk edges
  initial begin
    #102 div_in = 1'b0;
    forever #100 div_in = ~div_in;
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. Histories hold the input values seen at previous edges:
  // index 0 = last edge, 1 = two edges ago, 2 = three edges ago.
  bit m_div[3];
  bit m_run[2];
  bit m_btn[2];
  bit m_lvl, m_req, m_en, m_tick, m_runs, m_reqnow, m_fire;
  int m_diff, m_mode, m_cnt, m_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_div = '{0, 0, 0};
      m_run = '{0, 0};
      m_btn = '{0, 0};
      m_lvl = 0; m_req = 0; m_en = 0; m_diff = 0;
      m_mode = M_IDLE; m_cnt = 0;
    end else begin
      // a div_in rise first seen two edges ago, not three, makes this a tick cycle
      m_tick   = m_div[1] && !m_div[2];
      m_runs   = m_run[1];
      m_reqnow = m_req;
      m_req = 0;
      if (m_btn[1] != m_lvl) begin
        m_diff++;
        if (m_diff == DEB) begin
          m_lvl  = !m_lvl;
          m_diff = 0;
          m_req  = m_lvl;
        end
      end else begin
        m_diff = 0;
      end
      m_fire = 0;
      m_next = m_mode;
      if (m_mode != M_HALT && halt) m_next = M_HALT;
      else if (m_mode == M_IDLE) begin
        if (m_runs) m_next = M_RUN;
        else if (m_reqnow) m_next = M_STEP;
      end else if (m_mode == M_RUN) begin
        if (!m_runs) m_next = M_IDLE;
        else if (m_tick) m_fire = 1;
      end else if (m_mode == M_STEP && m_tick) begin
        m_fire = 1;
        m_next = M_IDLE;
      end
      m_mode = m_next;
      m_en   = m_fire;
      if (m_fire) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_div[2] = m_div[1]; m_div[1] = m_div[0]; m_div[0] = div_in;
      m_run[1] = m_run[0]; m_run[0] = run_sw;
      m_btn[1] = m_btn[0]; m_btn[0] = step_btn;
    end
  end

  bit prev_en = 0;
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_cpu_en", int'(cpu_en), int'(m_en));
      chk("model_running", int'(running), int'(m_mode == M_RUN));
      chk("model_halted", int'(halted), int'(m_mode == M_HALT));
      chk("model_instr_count", int'(instr_count), m_cnt);
      chk("no_back_to_back", int'(prev_en && cpu_en), 0);
      if (cpu_en) pulses++;
      prev_en = cpu_en;
    end else begin
      prev_en = 0;
    end
  end

  task automatic wait_until(input time t);
    while ($time < t) @(negedge clk);
  endtask

  int p0;

  initial begin
    // 1: reset with div_in already high
    #1 rst = 1'b1;
    wait_until(10);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_count", int'(instr_count), 0);
    #6 rst = 1'b0;
    wait_until(300);
    chk("idle_ignores_initial_tick", pulses, 0);
    chk("idle_running", int'(running), 0);
    chk("idle_count", int'(instr_count), 0);

    // 2: free-run for 1000 ns
    run_sw = 1'b1;
    wait_until(330);
    chk("run_entered", int'(running), 1);
    wait_until(420);
    chk("first_pulse_before", int'(cpu_en), 0);
    wait_until(430);
    chk("first_pulse_on", int'(cpu_en), 1);
    wait_until(440);
    chk("first_pulse_after", int'(cpu_en), 0);
    wait_until(1300);
    run_sw = 1'b0;
    wait_until(1340);
    chk("run_pulses", pulses, 5);
    chk("run_count", int'(instr_count), 5);
    chk("run_exit_idle", int'(running), 0);

    // 3a: bouncy step press
    p0 = pulses;
    wait_until(1420); step_btn = 1'b1;
    wait_until(1430); step_btn = 1'b0;
    wait_until(1440); step_btn = 1'b1;
    wait_until(1540); step_btn = 1'b0;
    wait_until(1630);
    chk("step_pulse_edge", int'(cpu_en), 1);
    wait_until(1700);
    chk("step_one_pulse", pulses - p0, 1);
    chk("step_count", int'(instr_count), 6);
    chk("step_back_idle", int'(running || halted), 0);

    // 3b: second press while STEP is still waiting
    p0 = pulses;
    wait_until(1810); step_btn = 1'b1;
    wait_until(1870); step_btn = 1'b0;
    wait_until(1930); step_btn = 1'b1;
    wait_until(1990); step_btn = 1'b0;
    wait_until(2090);
    chk("step_no_queue_pulses", pulses - p0, 1);
    chk("step_no_queue_count", int'(instr_count), 7);

    // 5: run switch dropped in the tick cycle
    p0 = pulses;
    wait_until(2100); run_sw = 1'b1;
    wait_until(2200); run_sw = 1'b0;
    wait_until(2230);
    chk("race_no_pulse_en", int'(cpu_en), 0);
    chk("race_idle", int'(running), 0);
    wait_until(2290);
    chk("race_pulses", pulses - p0, 0);
    chk("race_count", int'(instr_count), 7);

    // 4: halt coincident with tick wins
    p0 = pulses;
    wait_until(2300); run_sw = 1'b1;
    wait_until(2420); halt = 1'b1;
    wait_until(2430); halt = 1'b0;
    chk("halt_no_pulse", int'(cpu_en), 0);
    chk("halt_halted", int'(halted), 1);
    chk("halt_running", int'(running), 0);
    wait_until(2450); run_sw = 1'b0;
    wait_until(2460); step_btn = 1'b1;
    wait_until(2560); step_btn = 1'b0;
    wait_until(2600); run_sw = 1'b1;
    wait_until(2700); run_sw = 1'b0;
    wait_until(2880);
    chk("halt_sticky", int'(halted), 1);
    chk("halt_pulses", pulses - p0, 0);
    chk("halt_count", int'(instr_count), 7);

    // 6: counter wrap, then reset in the middle of a pulse
    wait_until(2890);
    rst = 1'b1;
    #1;
    chk("rst2_halted", int'(halted), 0);
    chk("rst2_count", int'(instr_count), 0);
    #15 rst = 1'b0;
    wait_until(2950); run_sw = 1'b1;
    wait_until(5840);
    chk("wrap_15", int'(instr_count), 15);
    wait_until(6040);
    chk("wrap_0", int'(instr_count), 0);
    wait_until(6230);
    chk("wrap_1", int'(instr_count), 1);
    chk("wrap_pulse_on", int'(cpu_en), 1);
    run_sw = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cpu_en", int'(cpu_en), 0);
    chk("async_rst_count", int'(instr_count), 0);
    chk("async_rst_running", int'(running), 0);
    #12 rst = 1'b0;
    wait_until(6320);
    chk("post_rst_idle", int'(running), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
